// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the MEM stage of the RV32IM pipeline.
// It services one load or store at a time over LATENCY cycles. BUSYWAIT stays
// high for the whole access, then the load result is returned sign- or
// zero-extended according to FUNCT3.
// Storage is word-organised with byte-lane write enables and is cleared on reset.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   - defined:   misaligned half/word accesses still run the full handshake.
//                Their stores are dropped, their loads return 0, and
//                MISALIGNED pulses high for the DONE cycle.
//   - undefined: the low address bits are truncated to the access alignment,
//                and MISALIGNED stays 0.

module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEMREAD,
    input  logic        MEMWRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic LAT_ONE = (LATENCY == 1) ? 1'b1 : 1'b0;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Control state
    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [31:0]     rdata_r;
    logic            mis_r;

    // Request fields captured when an access starts
    logic            is_load_r;
    logic            is_store_r;
    logic [2:0]      funct3_r;
    logic [AW+1:0]   addr_r;
    logic [31:0]     wdata_r;

    // Storage
    logic [31:0]     mem_r [0:DEPTH_WORDS-1];

    // Access currently being serviced: the live inputs in IDLE, the captured copy afterwards
    logic            cur_load_s;
    logic            cur_store_s;
    logic [2:0]      cur_funct3_s;
    logic [AW+1:0]   cur_addr_s;
    logic [31:0]     cur_wdata_s;

    logic            req_s;
    logic            commit_s;
    logic            trap_s;
    logic [1:0]      size_s;
    logic [1:0]      low_s;
    logic [AW-1:0]   word_idx_s;
    logic [31:0]     rd_word_s;
    logic [7:0]      rd_byte_s;
    logic [15:0]     rd_half_s;
    logic [31:0]     load_data_s;
    logic [3:0]      wmask_s;
    logic [31:0]     wmask_bits_s;
    logic [31:0]     wlane_data_s;
    logic            store_en_s;
    logic            addr_unused_s;

    assign req_s = MEMREAD | MEMWRITE;

    // Address bits above the array size are ignored (the address space wraps)
    assign addr_unused_s = ^ADDRESS[31:AW+2];

    // The core stalls in the request cycle itself, so BUSYWAIT is combinational in IDLE
    assign BUSYWAIT   = ((state_r == ST_IDLE) & req_s) | (state_r == ST_BUSY);
    assign READDATA   = rdata_r;
    assign MISALIGNED = mis_r;

    // Select the request fields: live inputs while idle, captured copy while in flight
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_load_s   = MEMREAD;
            cur_store_s  = MEMWRITE;
            cur_funct3_s = FUNCT3;
            cur_addr_s   = ADDRESS[AW+1:0];
            cur_wdata_s  = WRITEDATA;
        end else begin
            cur_load_s   = is_load_r;
            cur_store_s  = is_store_r;
            cur_funct3_s = funct3_r;
            cur_addr_s   = addr_r;
            cur_wdata_s  = wdata_r;
        end
    end

    // Commit happens on the edge that enters DONE
    always_comb begin
        commit_s = 1'b0;
        case (state_r)
            ST_IDLE: commit_s = req_s & LAT_ONE;
            ST_BUSY: commit_s = (cnt_r <= CW'(1));
            default: commit_s = 1'b0;
        endcase
    end

    // Decode the access size; a store takes priority when both requests are high
    always_comb begin
        size_s = SZ_WORD;
        if (cur_store_s) begin
            case (cur_funct3_s)
                3'b000:  size_s = SZ_BYTE;
                3'b001:  size_s = SZ_HALF;
                default: size_s = SZ_WORD;
            endcase
        end else begin
            case (cur_funct3_s)
                3'b000, 3'b100: size_s = SZ_BYTE;
                3'b001, 3'b101: size_s = SZ_HALF;
                default:        size_s = SZ_WORD;
            endcase
        end
    end

    // Lane offset truncated to the access alignment
    always_comb begin
        case (size_s)
            SZ_BYTE: low_s = cur_addr_s[1:0];
            SZ_HALF: low_s = {cur_addr_s[1], 1'b0};
            default: low_s = 2'b00;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Flag half accesses on odd addresses and word accesses off a word boundary
    always_comb begin
        case (size_s)
            SZ_HALF: trap_s = cur_addr_s[0];
            SZ_WORD: trap_s = |cur_addr_s[1:0];
            default: trap_s = 1'b0;
        endcase
    end
`else
    assign trap_s = 1'b0;
`endif

    assign word_idx_s = cur_addr_s[AW+1:2];
    assign rd_word_s  = mem_r[word_idx_s];

    // Pick the addressed byte and half out of the stored word (little-endian)
    always_comb begin
        case (low_s)
            2'd0:    rd_byte_s = rd_word_s[7:0];
            2'd1:    rd_byte_s = rd_word_s[15:8];
            2'd2:    rd_byte_s = rd_word_s[23:16];
            2'd3:    rd_byte_s = rd_word_s[31:24];
            default: rd_byte_s = 8'h00;
        endcase
        if (low_s[1]) begin
            rd_half_s = rd_word_s[31:16];
        end else begin
            rd_half_s = rd_word_s[15:0];
        end
    end

    // Extend the load result; a combined read+write or a trapped access returns zero
    always_comb begin
        load_data_s = 32'h0000_0000;
        if (cur_store_s | trap_s) begin
            load_data_s = 32'h0000_0000;
        end else begin
            case (cur_funct3_s)
                3'b000:  load_data_s = {{24{rd_byte_s[7]}}, rd_byte_s};
                3'b001:  load_data_s = {{16{rd_half_s[15]}}, rd_half_s};
                3'b100:  load_data_s = {24'h00_0000, rd_byte_s};
                3'b101:  load_data_s = {16'h0000, rd_half_s};
                default: load_data_s = rd_word_s;
            endcase
        end
    end

    // Build the byte-lane enables and the replicated store data
    always_comb begin
        case (size_s)
            SZ_BYTE: begin
                wmask_s      = 4'b0001 << low_s;
                wlane_data_s = {4{cur_wdata_s[7:0]}};
            end
            SZ_HALF: begin
                wmask_s      = low_s[1] ? 4'b1100 : 4'b0011;
                wlane_data_s = {2{cur_wdata_s[15:0]}};
            end
            default: begin
                wmask_s      = 4'b1111;
                wlane_data_s = cur_wdata_s;
            end
        endcase
    end

    assign wmask_bits_s = {{8{wmask_s[3]}}, {8{wmask_s[2]}}, {8{wmask_s[1]}}, {8{wmask_s[0]}}};
    assign store_en_s   = commit_s & cur_store_s & ~trap_s;

    // Handshake FSM, latency counter, request capture and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CW'(0);
            rdata_r    <= 32'h0000_0000;
            mis_r      <= 1'b0;
            is_load_r  <= 1'b0;
            is_store_r <= 1'b0;
            funct3_r   <= 3'b000;
            addr_r     <= {(AW+2){1'b0}};
            wdata_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        is_load_r  <= MEMREAD;
                        is_store_r <= MEMWRITE;
                        funct3_r   <= FUNCT3;
                        addr_r     <= ADDRESS[AW+1:0];
                        wdata_r    <= WRITEDATA;
                        if (LAT_ONE) begin
                            state_r <= ST_DONE;
                            cnt_r   <= CW'(0);
                        end else begin
                            state_r <= ST_BUSY;
                            cnt_r   <= CNT_LOAD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r <= CW'(1)) begin
                        state_r <= ST_DONE;
                        cnt_r   <= CW'(0);
                    end else begin
                        cnt_r   <= cnt_r - CW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CW'(0);
                end
            endcase

            if (commit_s) begin
                if (cur_load_s) begin
                    rdata_r <= load_data_s;
                end else begin
                    rdata_r <= rdata_r;
                end
                mis_r <= trap_s;
            end else begin
                mis_r <= 1'b0;
            end
        end
    end

    // Word array: cleared on reset, byte-lane merge on a committed store
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (store_en_s) begin
            mem_r[word_idx_s] <= (rd_word_s & ~wmask_bits_s) | (wlane_data_s & wmask_bits_s);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. A byte-level memory model and an
// expected-value queue track loads. Directed cases follow the plan:
// store/load, extension, byte lanes, wrap-around, misalignment, latching
// and reset mid-access. A run of random back-to-back accesses follows.

module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;
    localparam int BYTES = 4 * DEPTH;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        MEMREAD = 1'b0;
    logic        MEMWRITE = 1'b0;
    logic [2:0]  FUNCT3 = 3'b000;
    logic [31:0] ADDRESS = 32'h0;
    logic [31:0] WRITEDATA = 32'h0;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    logic [7:0]  mb [0:BYTES-1];

    always #5 CLK = ~CLK;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
        .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
        .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
        int a = int'(addr % BYTES);
        case (f3)
            3'b000: mb[a] = wd[7:0];
            3'b001: begin
                a = a & ~1;
                mb[a] = wd[7:0]; mb[a+1] = wd[15:8];
            end
            default: begin
                a = a & ~3;
                mb[a] = wd[7:0]; mb[a+1] = wd[15:8]; mb[a+2] = wd[23:16]; mb[a+3] = wd[31:24];
            end
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        int a = int'(addr % BYTES);
        int wa = a & ~3;
        int ha = a & ~1;
        logic [7:0]  b = mb[a];
        logic [15:0] h = {mb[ha+1], mb[ha]};
        logic [31:0] w = {mb[wa+3], mb[wa+2], mb[wa+1], mb[wa]};
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Drive one request, hold it until BUSYWAIT falls, then release it after the DONE edge
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input bit scramble,
                          output int busy_n, output int mis_n, output logic [31:0] rdata);
        bit done = 0;
        busy_n = 0; mis_n = 0; rdata = 32'h0;
        MEMREAD = rd; MEMWRITE = wr; FUNCT3 = f3; ADDRESS = addr; WRITEDATA = wd;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (MISALIGNED) mis_n++;
            if (BUSYWAIT) begin
                busy_n++;
                if (scramble && busy_n == 2) begin
                    ADDRESS = ~addr; WRITEDATA = ~wd; FUNCT3 = f3 ^ 3'b011;
                end
            end else begin
                rdata = READDATA;
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL access_timeout: BUSYWAIT still high after 20 cycles, addr=%h", addr);
        end
        @(posedge CLK); #1;
        if (MISALIGNED) mis_n++;
        MEMREAD = 1'b0; MEMWRITE = 1'b0;
        if (wr) model_store(addr, f3, wd);
    endtask

    task automatic test_reset();
        int bn, mn; logic [31:0] rv, ev;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        model_clear();
        @(negedge CLK);
        checks++; if (READDATA !== 32'h0) begin failures++; $display("FAIL reset_readdata: got %h want 00000000", READDATA); end
        checks++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL reset_busywait: got %b want 0", BUSYWAIT); end
        checks++; if (MISALIGNED !== 1'b0) begin failures++; $display("FAIL reset_misaligned: got %b want 0", MISALIGNED); end
        exp_q.push_back(32'h0);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 0, bn, mn, rv);
        ev = exp_q.pop_front();
        checks++; if (rv !== ev) begin failures++; $display("FAIL reset_array_clear: got %h want %h", rv, ev); end
    endtask

    task automatic test_store_load();
        int bn, mn; logic [31:0] rv, ev;
        access(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, bn, mn, rv);
        checks++; if (bn !== LAT) begin failures++; $display("FAIL sw_busy_cycles: got %0d want %0d", bn, LAT); end
        exp_q.push_back(32'hDEAD_BEEF);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 0, bn, mn, rv);
        checks++; if (bn !== LAT) begin failures++; $display("FAIL lw_busy_cycles: got %0d want %0d", bn, LAT); end
        ev = exp_q.pop_front();
        checks++; if (rv !== ev) begin failures++; $display("FAIL lw_data: got %h want %h", rv, ev); end
    endtask

    task automatic test_extension();
        int bn, mn; logic [31:0] rv, ev;
        logic [31:0] a_t [0:4];
        logic [2:0]  f_t [0:4];
        logic [31:0] e_t [0:4];
        a_t[0] = 32'hF0; f_t[0] = 3'b000; e_t[0] = 32'h0000_007F;
        a_t[1] = 32'hF1; f_t[1] = 3'b000; e_t[1] = 32'hFFFF_FF80;
        a_t[2] = 32'hF1; f_t[2] = 3'b100; e_t[2] = 32'h0000_0080;
        a_t[3] = 32'hF2; f_t[3] = 3'b001; e_t[3] = 32'hFFFF_8001;
        a_t[4] = 32'hF2; f_t[4] = 3'b101; e_t[4] = 32'h0000_8001;
        access(1'b0, 1'b1, 3'b010, 32'h0000_00F0, 32'h8001_807F, 0, bn, mn, rv);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(e_t[i]);
            access(1'b1, 1'b0, f_t[i], a_t[i], 32'h0, 0, bn, mn, rv);
            ev = exp_q.pop_front();
            checks++; if (rv !== ev) begin failures++; $display("FAIL extension_%0d: got %h want %h", i, rv, ev); end
        end
    endtask

    task automatic test_byte_lanes();
        int bn, mn; logic [31:0] rv, ev;
        access(1'b0, 1'b1, 3'b010, 32'h20, 32'h1122_3344, 0, bn, mn, rv);
        access(1'b0, 1'b1, 3'b000, 32'h22, 32'hFFFF_FFAA, 0, bn, mn, rv);
        access(1'b0, 1'b1, 3'b001, 32'h20, 32'h5555_BBCC, 0, bn, mn, rv);
        checks++; if (READDATA !== 32'h0000_8001) begin failures++; $display("FAIL store_keeps_readdata: got %h want 00008001", READDATA); end
        exp_q.push_back(32'h11AA_BBCC);
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0, bn, mn, rv);
        ev = exp_q.pop_front();
        checks++; if (rv !== ev) begin failures++; $display("FAIL byte_lanes: got %h want %h", rv, ev); end
    endtask

    task automatic test_wrap();
        int bn, mn; logic [31:0] rv, ev;
        access(1'b0, 1'b1, 3'b010, 32'h0, 32'h0000_0005, 0, bn, mn, rv);
        exp_q.push_back(32'h0000_0005);
        access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 0, bn, mn, rv);
        ev = exp_q.pop_front();
        checks++; if (rv !== ev) begin failures++; $display("FAIL wrap_around: got %h want %h", rv, ev); end
    endtask

    task automatic test_misaligned();
        int bn, mn, emis; logic [31:0] rv, ev, ev2;
`ifdef DMEM_MISALIGN_TRAP_EN
        ev = 32'h0; ev2 = 32'h0; emis = 1;
`else
        ev = 32'hDEAD_BEEF; ev2 = 32'hFFFF_BEEF; emis = 0;
`endif
        exp_q.push_back(ev);
        access(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, 0, bn, mn, rv);
        ev = exp_q.pop_front();
        checks++; if (rv !== ev) begin failures++; $display("FAIL misaligned_lw_data: got %h want %h", rv, ev); end
        checks++; if (mn !== emis) begin failures++; $display("FAIL misaligned_lw_flag_cycles: got %0d want %0d", mn, emis); end
        checks++; if (bn !== LAT) begin failures++; $display("FAIL misaligned_busy_cycles: got %0d want %0d", bn, LAT); end
        exp_q.push_back(ev2);
        access(1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 0, bn, mn, rv);
        ev = exp_q.pop_front();
        checks++; if (rv !== ev) begin failures++; $display("FAIL misaligned_lh_data: got %h want %h", rv, ev); end
        checks++; if (mn !== emis) begin failures++; $display("FAIL misaligned_lh_flag_cycles: got %0d want %0d", mn, emis); end
    endtask

    task automatic test_latching();
        int bn, mn; logic [31:0] rv, ev;
        access(1'b0, 1'b1, 3'b010, 32'h40, 32'h0BAD_F00D, 1, bn, mn, rv);
        exp_q.push_back(32'h0BAD_F00D);
        access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1, bn, mn, rv);
        ev = exp_q.pop_front();
        checks++; if (rv !== ev) begin failures++; $display("FAIL request_latched: got %h want %h", rv, ev); end
    endtask

    task automatic test_back_to_back();
        int bn, mn, sel; logic [31:0] rv, ev, addr, wd; logic [2:0] f3; logic rd, wr;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 7);
            wd = $urandom;
            f3 = 3'($urandom_range(0, 7));
            addr = 32'h100 + 32'($urandom_range(0, 63));
            wr = (sel < 3) || (sel == 7);
            rd = (sel >= 3);
            if (wr) begin
                if (f3 == 3'b001) addr = addr & ~32'h1;
                else if (f3 != 3'b000) addr = addr & ~32'h3;
            end else begin
                if (f3 == 3'b001 || f3 == 3'b101) addr = addr & ~32'h1;
                else if (f3 != 3'b000 && f3 != 3'b100) addr = addr & ~32'h3;
            end
            if (rd) exp_q.push_back(wr ? 32'h0 : model_load(addr, f3));
            access(rd, wr, f3, addr, wd, 0, bn, mn, rv);
            checks++; if (bn !== LAT) begin failures++; $display("FAIL b2b_busy_%0d: got %0d want %0d", i, bn, LAT); end
            if (rd) begin
                ev = exp_q.pop_front();
                checks++; if (rv !== ev) begin failures++; $display("FAIL b2b_data_%0d: got %h want %h (f3=%b addr=%h wr=%b)", i, rv, ev, f3, addr, wr); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bn, mn; logic [31:0] rv, ev;
        exp_q.push_back(32'hDEAD_BEEF);
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, bn, mn, rv);
        ev = exp_q.pop_front();
        checks++; if (rv !== ev) begin failures++; $display("FAIL pre_reset_load: got %h want %h", rv, ev); end
        MEMWRITE = 1'b1; FUNCT3 = 3'b010; ADDRESS = 32'h30; WRITEDATA = 32'hFFFF_FFFF;
        @(posedge CLK);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0; MEMWRITE = 1'b0;
        model_clear();
        @(negedge CLK);
        checks++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL reset_mid_busywait: got %b want 0", BUSYWAIT); end
        checks++; if (READDATA !== 32'h0) begin failures++; $display("FAIL reset_mid_readdata: got %h want 00000000", READDATA); end
        checks++; if (MISALIGNED !== 1'b0) begin failures++; $display("FAIL reset_mid_misaligned: got %b want 0", MISALIGNED); end
        @(posedge CLK); #1;
        exp_q.push_back(32'h0);
        access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 0, bn, mn, rv);
        checks++; if (bn !== LAT) begin failures++; $display("FAIL reset_mid_next_busy: got %0d want %0d", bn, LAT); end
        ev = exp_q.pop_front();
        checks++; if (rv !== ev) begin failures++; $display("FAIL reset_mid_store_dropped: got %h want %h", rv, ev); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extension();
        test_byte_lanes();
        test_wrap();
        test_misaligned();
        test_latching();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32IM pipeline's MEM stage. It accepts load and store requests from the EX/MEM pipeline register and services them over a configurable multi-cycle latency. It holds `BUSYWAIT` high until each access completes, then returns load data byte/half/word-extended per `FUNCT3`. Its storage is word-organised with byte-lane writes. It is the slave end of the MEMREAD/MEMWRITE/BUSYWAIT handshake that the core uses to stall its pipeline.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; must be a power of 2. `AW = log2(DEPTH_WORDS)`.
- `LATENCY`, 3: cycles `BUSYWAIT` is high per access, counting the request cycle; legal range ≥ 1.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high.
- `MEMREAD` input 1: load request level, held until completion.
- `MEMWRITE` input 1: store request level, held until completion.
- `FUNCT3` input 3: access size/sign, from the instruction.
- `ADDRESS` input 32: byte address (ALU result).
- `WRITEDATA` input 32: store data; the low byte/half is used for SB/SH.
- `READDATA` output 32: extended load data.
- `BUSYWAIT` output 1: stall request to the core.
- `MISALIGNED` output 1: one-cycle flag on a suppressed misaligned access (see Configuration).

## Operation
- Word index is `ADDRESS[AW+1:2]`. Higher address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- FSM states:
  - IDLE, the reset state.
  - BUSY, which uses a down-counter.
  - DONE.
- IDLE → BUSY when `MEMREAD|MEMWRITE` is high. The counter loads `LATENCY-1`. If `LATENCY==1`, IDLE goes directly to DONE.
- BUSY: the counter decrements each cycle. When the counter reaches 0, BUSY → DONE.
- On entry to DONE:
  - A store commits to the array.
  - A load registers its result into `READDATA`.
- DONE → IDLE unconditionally. A request still asserted during DONE is the one that just completed; the core advances at the edge leaving DONE.
- `BUSYWAIT` = (IDLE & (MEMREAD|MEMWRITE)) | BUSY. This makes `BUSYWAIT` combinational in IDLE so the core stalls in the request cycle. `BUSYWAIT` is 0 in DONE.
- Request fields are sampled at the IDLE→BUSY edge into internal registers. Later changes to the inputs do not affect the access in flight.
- Load `FUNCT3` encodings:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - 011, 110, 111: treated as LW.
- Byte/half lane selection uses `ADDRESS[1:0]` (little-endian).
- Store `FUNCT3` encodings:
  - 000 SB: write one byte lane.
  - 001 SH: write two byte lanes.
  - 010 SW: write all four lanes.
  - All others: treated as SW.
- If `MEMREAD` and `MEMWRITE` are both high, the store takes priority and `READDATA` is set to 0 at DONE.
- `READDATA` holds its value until the next load completes. Stores do not change `READDATA`.

## Timing
- Reset values: `READDATA=0`, `MISALIGNED=0`, state IDLE, counter 0. `BUSYWAIT` follows its equation: 0 with no request.
- On reset, array contents are cleared to 0.
- Latency: a request in cycle t is completed (DONE) in cycle t+LATENCY. `READDATA` is valid from t+LATENCY.
- `RESET` asserted during BUSY: an uncommitted store is discarded, the FSM returns to IDLE, and the outputs take their reset values at the next edge.
- `RESET` asserted in the cycle DONE is entered: reset wins and the store is not committed.
- Back-to-back requests: the minimum spacing between request starts is LATENCY+1 cycles, because of the mandatory DONE→IDLE transition.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `ADDRESS[0]=1` is misaligned.
  - LW/SW with `ADDRESS[1:0]!=0` is misaligned.
  - A misaligned access still runs the full handshake.
  - At DONE: stores are suppressed, loads return 0, and `MISALIGNED` pulses high for the DONE cycle.
- Undefined:
  - `ADDRESS` low bits are truncated to the access alignment: bit 0 for half accesses, bits 1:0 for word accesses.
  - The access proceeds normally.
  - `MISALIGNED` is tied to 0.

## Test plan
- Store then load: SW 0xDEADBEEF to 0x10, then LW 0x10. `BUSYWAIT` is high exactly 3 cycles for each access, and `READDATA` is 0xDEADBEEF at DONE.
- Extension: from word 0x000000F0 = 0x8001807F:
  - LB 0xF0 → 0x0000007F.
  - LB 0xF1 → 0xFFFFFF80.
  - LBU 0xF1 → 0x00000080.
  - LH 0xF2 → 0xFFFF8001.
  - LHU 0xF2 → 0x00008001.
- Byte-lane store: SW 0x11223344 to 0x20, SB 0xAA to 0x22, SH 0xBBCC to 0x20, then LW 0x20 → 0x11AABBCC.
- Wrap-around: SW 0x5 to 0x0, then LW at address 4*DEPTH_WORDS (0x400 for the default depth) → 0x00000005.
- Reset mid-access: SW 0xFFFFFFFF to 0x30 with `RESET` pulsed in the second BUSY cycle. `BUSYWAIT` drops, the FSM is IDLE, and a subsequent LW 0x30 → 0.
- Misaligned: LW 0x13.
  - With `DMEM_MISALIGN_TRAP_EN`: `READDATA`=0 and `MISALIGNED` is 1 for exactly one cycle.
  - Without it: returns the word at 0x10 and `MISALIGNED` stays 0.
